fetch_queue: RTL

//  Instruction-fetch stage on the instruction side of the unified byte memory.

---
 rtl/fetch_queue.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fetch_queue.sv
// Instruction fetch stage: owns fetch PC, prefetch FIFO, valid/ready to decode.
// Optional halt on SYSTEM opcode via FETCH_HALT_ON_SYSTEM_EN.
module fetch_queue #(
  parameter int                ADDR_W   = 9,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic              imem_en,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [31:0]       if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              misalign_err,
  output logic              halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [31:0] NOP = 32'h00000013;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]     count_q, count_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic              misalign_q, misalign_d;
  logic [ADDR_W-1:0] pc_mem_q [DEPTH];
  logic [ADDR_W-1:0] pc_mem_d [DEPTH];
  logic [31:0]       instr_mem_q [DEPTH];
  logic [31:0]       instr_mem_d [DEPTH];
  logic              halted_q;
  logic              pop;
  logic              push;

`ifdef FETCH_HALT_ON_SYSTEM_EN
  logic halted_d;
`else
  assign halted_q = 1'b0;
`endif

  assign if_valid     = rst_n & (count_q != '0);
  assign pop          = if_valid & if_ready;
  assign push         = rst_n & ~redirect_valid & ~misalign_q & ~halted_q
                      & ((count_q < DEPTH_C) | pop);
  assign imem_en      = push;
  assign imem_addr    = fetch_pc_q;
  assign if_instr     = if_valid ? instr_mem_q[rd_ptr_q] : NOP;
  assign if_pc        = if_valid ? pc_mem_q[rd_ptr_q] : '0;
  assign misalign_err = misalign_q;
  assign halted       = halted_q;

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    count_d     = count_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    misalign_d  = misalign_q;
    pc_mem_d    = pc_mem_q;
    instr_mem_d = instr_mem_q;
    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      if (redirect_pc[1:0] == 2'b00) begin
        fetch_pc_d = redirect_pc;
        misalign_d = 1'b0;
      end else begin
        misalign_d = 1'b1;
      end
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]    = fetch_pc_q;
        instr_mem_d[wr_ptr_q] = imem_rdata;
        wr_ptr_d              = wr_ptr_q + 1'b1;
        fetch_pc_d            = fetch_pc_q + ADDR_W'(4);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

`ifdef FETCH_HALT_ON_SYSTEM_EN
  // The SYSTEM word is still queued; only later pushes are blocked.
  always_comb begin
    halted_d = halted_q;
    if (redirect_valid) begin
      if (redirect_pc[1:0] == 2'b00) halted_d = 1'b0;
    end else if (push && imem_rdata[6:0] == OP_SYSTEM) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) halted_q <= 1'b0;
    else        halted_q <= halted_d;
  end
`else
  logic unused_op;
  assign unused_op = &{1'b0, OP_SYSTEM};
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      misalign_q <= 1'b0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      misalign_q <= misalign_d;
    end
  end

  always_ff @(posedge clk) begin
    pc_mem_q    <= pc_mem_d;
    instr_mem_q <= instr_mem_d;
  end

endmodule
